// File: rtl/data_bypass_sb.sv
// ID-stage operand forwarding unit with long-latency pending scoreboard.
// Optional performance counters are enabled with `define DATA_BYPASS_PERF_EN.
module data_bypass_sb #(
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AW      = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_RD-1:0]         id_rd_en,
  input  logic [NUM_RD*AW-1:0]      id_rd_addr,
  output logic [NUM_RD*XLEN-1:0]    id_rd_data,
  output logic                      id_stall,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*AW-1:0]     fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_data_ok,
  input  logic                      lat_issue,
  input  logic [AW-1:0]             lat_issue_addr,
  input  logic                      lat_done,
  input  logic [AW-1:0]             lat_done_addr,
  input  logic [XLEN-1:0]           lat_done_data,
  input  logic                      sb_flush,
  output logic [NUM_RD-1:0]         rf_rd_en,
  output logic [NUM_RD*AW-1:0]      rf_rd_addr,
  input  logic [NUM_RD*XLEN-1:0]    rf_rd_data
`ifdef DATA_BYPASS_PERF_EN
  ,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_fwd_cnt
`endif
);

  localparam int unsigned NREG = 1 << AW;

  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic [NUM_RD-1:0] ch_stall;
`ifdef DATA_BYPASS_PERF_EN
  logic [NUM_RD-1:0] ch_served;
`endif

  assign rf_rd_addr = id_rd_addr;

  // Per-channel source resolution: youngest fwd stage, then lat_done, then pending, then RF.
  always_comb begin
    logic [AW-1:0] addr;
    logic          found;
    id_rd_data = '0;
    rf_rd_en   = '0;
    ch_stall   = '0;
`ifdef DATA_BYPASS_PERF_EN
    ch_served  = '0;
`endif
    for (int k = 0; k < NUM_RD; k++) begin
      addr  = id_rd_addr[k*AW +: AW];
      found = 1'b0;
      if (id_rd_en[k] && (addr != '0)) begin
        for (int s = 0; s < NUM_FWD; s++) begin
          if (!found && fwd_valid[s] && (fwd_addr[s*AW +: AW] == addr)) begin
            found = 1'b1;
            if (fwd_data_ok[s]) begin
              id_rd_data[k*XLEN +: XLEN] = fwd_data[s*XLEN +: XLEN];
`ifdef DATA_BYPASS_PERF_EN
              ch_served[k] = 1'b1;
`endif
            end else begin
              ch_stall[k] = 1'b1;
            end
          end
        end
        if (!found) begin
          if (lat_done && (lat_done_addr == addr)) begin
            id_rd_data[k*XLEN +: XLEN] = lat_done_data;
`ifdef DATA_BYPASS_PERF_EN
            ch_served[k] = 1'b1;
`endif
          end else if (pending[addr]) begin
            ch_stall[k] = 1'b1;
          end else begin
            rf_rd_en[k] = 1'b1;
            id_rd_data[k*XLEN +: XLEN] = rf_rd_data[k*XLEN +: XLEN];
          end
        end
      end
    end
    id_stall = |ch_stall;
  end

  // Done clears before issue sets, so same-address done+issue leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    if (lat_done && (lat_done_addr != '0)) pending_nxt[lat_done_addr] = 1'b0;
    if (lat_issue && (lat_issue_addr != '0)) pending_nxt[lat_issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || sb_flush) pending <= '0;
    else                   pending <= pending_nxt;
  end

`ifdef DATA_BYPASS_PERF_EN
  // Saturating event counters; sb_flush intentionally has no effect here.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (id_stall && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if ((|ch_served) && (perf_fwd_cnt != 32'hFFFF_FFFF))
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_bypass_sb.sv
// Directed self-checking bench for data_bypass_sb (default configuration).
module tb_data_bypass_sb;

  localparam int unsigned NUM_RD  = 2;
  localparam int unsigned NUM_FWD = 3;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned AW      = 5;
  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hBBBB_0001;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_RD-1:0]       id_rd_en;
  logic [NUM_RD*AW-1:0]    id_rd_addr;
  logic [NUM_RD*XLEN-1:0]  id_rd_data;
  logic                    id_stall;
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [NUM_FWD*AW-1:0]   fwd_addr;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic [NUM_FWD-1:0]      fwd_data_ok;
  logic                    lat_issue;
  logic [AW-1:0]           lat_issue_addr;
  logic                    lat_done;
  logic [AW-1:0]           lat_done_addr;
  logic [XLEN-1:0]         lat_done_data;
  logic                    sb_flush;
  logic [NUM_RD-1:0]       rf_rd_en;
  logic [NUM_RD*AW-1:0]    rf_rd_addr;
  logic [NUM_RD*XLEN-1:0]  rf_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  wire [31:0] d0 = id_rd_data[31:0];
  wire [31:0] d1 = id_rd_data[63:32];

  data_bypass_sb #(.NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr), .id_rd_data(id_rd_data), .id_stall(id_stall),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok),
    .lat_issue(lat_issue), .lat_issue_addr(lat_issue_addr),
    .lat_done(lat_done), .lat_done_addr(lat_done_addr), .lat_done_data(lat_done_data),
    .sb_flush(sb_flush), .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
  );

  always #5 clk = ~clk;

  task tick;
    @(negedge clk);
  endtask

  task idle;
    id_rd_en = '0; id_rd_addr = '0;
    fwd_valid = '0; fwd_addr = '0; fwd_data = '0; fwd_data_ok = '0;
    lat_issue = 1'b0; lat_issue_addr = '0;
    lat_done = 1'b0; lat_done_addr = '0; lat_done_data = '0;
    sb_flush = 1'b0;
    rf_rd_data = {RF1, RF0};
  endtask

  task test_reset;
    reset = 1'b1; idle; tick; tick;
    reset = 1'b0;
    id_rd_en = 2'b11; id_rd_addr = {5'd2, 5'd1}; #1;
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", id_stall); end
    n_checks++; if (rf_rd_en !== 2'b11) begin n_fail++; $display("FAIL reset_rf_en got=%b exp=11", rf_rd_en); end
    n_checks++; if (id_rd_data !== {RF1, RF0}) begin n_fail++; $display("FAIL reset_rf_data got=%h exp=%h", id_rd_data, {RF1, RF0}); end
    n_checks++; if (rf_rd_addr !== {5'd2, 5'd1}) begin n_fail++; $display("FAIL rf_addr got=%h exp=%h", rf_rd_addr, {5'd2, 5'd1}); end
    tick;
  endtask

  task test_fwd_priority;
    idle;
    fwd_valid = 3'b111; fwd_addr = {5'd5, 5'd5, 5'd5};
    fwd_data = {32'h33, 32'h22, 32'h11}; fwd_data_ok = 3'b111;
    id_rd_en = 2'b01; id_rd_addr = {5'd0, 5'd5}; #1;
    n_checks++; if (d0 !== 32'h11) begin n_fail++; $display("FAIL fwd_prio_data got=%h exp=11", d0); end
    n_checks++; if (rf_rd_en[0] !== 1'b0) begin n_fail++; $display("FAIL fwd_prio_rfen got=%b exp=0", rf_rd_en[0]); end
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_prio_stall got=%b exp=0", id_stall); end
    fwd_valid = 3'b110; #1;
    n_checks++; if (d0 !== 32'h22) begin n_fail++; $display("FAIL fwd_stage1 got=%h exp=22", d0); end
    fwd_valid = 3'b100; id_rd_en = 2'b10; id_rd_addr = {5'd5, 5'd0}; #1;
    n_checks++; if (d1 !== 32'h33 || d0 !== 32'h0) begin n_fail++; $display("FAIL fwd_stage2_ch1 got=%h exp=%h", id_rd_data, {32'h33, 32'h0}); end
    fwd_valid = 3'b111; fwd_data_ok = 3'b110; id_rd_en = 2'b01; id_rd_addr = {5'd0, 5'd5}; #1;
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL fwd_young_notok got=%b exp=1", id_stall); end
    tick;
  endtask

  task test_load_use;
    idle;
    fwd_valid = 3'b001; fwd_addr = {5'd0, 5'd0, 5'd7}; fwd_data_ok = 3'b000;
    id_rd_en = 2'b10; id_rd_addr = {5'd7, 5'd0}; #1;
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall got=%b exp=1", id_stall); end
    tick; idle;
    fwd_valid = 3'b010; fwd_addr = {5'd0, 5'd7, 5'd0}; fwd_data = {32'h0, 32'hDEAD, 32'h0}; fwd_data_ok = 3'b010;
    id_rd_en = 2'b10; id_rd_addr = {5'd7, 5'd0}; #1;
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release got=%b exp=0", id_stall); end
    n_checks++; if (d1 !== 32'hDEAD) begin n_fail++; $display("FAIL load_use_data got=%h exp=dead", d1); end
    tick;
  endtask

  task test_scoreboard;
    idle; lat_issue = 1'b1; lat_issue_addr = 5'd9; tick;
    for (int c = 1; c <= 3; c++) begin
      idle; id_rd_en = 2'b01; id_rd_addr = {5'd0, 5'd9}; #1;
      n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL sb_pending_c%0d got=%b exp=1", c, id_stall); end
      tick;
    end
    idle; id_rd_en = 2'b01; id_rd_addr = {5'd0, 5'd9};
    lat_done = 1'b1; lat_done_addr = 5'd9; lat_done_data = 32'hCAFE; #1;
    n_checks++; if (d0 !== 32'hCAFE || id_stall !== 1'b0) begin n_fail++; $display("FAIL sb_done_bypass got=%h/%b exp=cafe/0", d0, id_stall); end
    tick;
    idle; id_rd_en = 2'b01; id_rd_addr = {5'd0, 5'd9}; #1;
    n_checks++; if (rf_rd_en[0] !== 1'b1 || d0 !== RF0 || id_stall !== 1'b0) begin n_fail++; $display("FAIL sb_cleared got=%b/%h exp=1/%h", rf_rd_en[0], d0, RF0); end
    tick;
    // Younger fwd hit wins over a pending bit
    idle; lat_issue = 1'b1; lat_issue_addr = 5'd12; tick;
    idle; fwd_valid = 3'b100; fwd_addr = {5'd12, 5'd0, 5'd0}; fwd_data = {32'h77, 64'h0}; fwd_data_ok = 3'b100;
    id_rd_en = 2'b10; id_rd_addr = {5'd12, 5'd0}; #1;
    n_checks++; if (d1 !== 32'h77 || id_stall !== 1'b0) begin n_fail++; $display("FAIL waw_fwd got=%h/%b exp=77/0", d1, id_stall); end
    fwd_valid = 3'b000; #1;
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL waw_pending got=%b exp=1", id_stall); end
    idle; lat_done = 1'b1; lat_done_addr = 5'd12; tick;
    // Done to a non-pending register is harmless
    idle; lat_done = 1'b1; lat_done_addr = 5'd20; tick;
    idle; id_rd_en = 2'b01; id_rd_addr = {5'd0, 5'd20}; #1;
    n_checks++; if (id_stall !== 1'b0 || rf_rd_en !== 2'b01) begin n_fail++; $display("FAIL done_nonpending got=%b/%b exp=0/01", id_stall, rf_rd_en); end
    tick;
  endtask

  task test_flush;
    idle; lat_issue = 1'b1; lat_issue_addr = 5'd3; tick;
    idle; lat_issue = 1'b1; lat_issue_addr = 5'd4; tick;
    idle; id_rd_en = 2'b11; id_rd_addr = {5'd4, 5'd3}; #1;
    n_checks++; if (id_stall !== 1'b1 || rf_rd_en !== 2'b00) begin n_fail++; $display("FAIL flush_pre got=%b/%b exp=1/00", id_stall, rf_rd_en); end
    idle; sb_flush = 1'b1; lat_issue = 1'b1; lat_issue_addr = 5'd6; tick;
    idle; id_rd_en = 2'b11; id_rd_addr = {5'd4, 5'd3}; #1;
    n_checks++; if (id_stall !== 1'b0 || rf_rd_en !== 2'b11) begin n_fail++; $display("FAIL flush_x3x4 got=%b/%b exp=0/11", id_stall, rf_rd_en); end
    id_rd_en = 2'b01; id_rd_addr = {5'd0, 5'd6}; #1;
    n_checks++; if (id_stall !== 1'b0 || rf_rd_en !== 2'b01) begin n_fail++; $display("FAIL flush_x6 got=%b/%b exp=0/01", id_stall, rf_rd_en); end
    tick;
  endtask

  task test_done_issue_same;
    idle; lat_issue = 1'b1; lat_issue_addr = 5'd10; tick;
    idle; lat_issue = 1'b1; lat_issue_addr = 5'd10;
    lat_done = 1'b1; lat_done_addr = 5'd10; lat_done_data = 32'h55;
    id_rd_en = 2'b01; id_rd_addr = {5'd0, 5'd10}; #1;
    n_checks++; if (d0 !== 32'h55 || id_stall !== 1'b0) begin n_fail++; $display("FAIL same_cyc_bypass got=%h/%b exp=55/0", d0, id_stall); end
    tick;
    idle; id_rd_en = 2'b01; id_rd_addr = {5'd0, 5'd10}; #1;
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL same_cyc_pending got=%b exp=1", id_stall); end
    idle; lat_done = 1'b1; lat_done_addr = 5'd10; tick;
  endtask

  task test_x0_reset;
    idle;
    fwd_valid = 3'b001; fwd_addr = '0; fwd_data = {64'h0, 32'hFFFF}; fwd_data_ok = 3'b001;
    lat_issue = 1'b1; lat_issue_addr = 5'd0;
    id_rd_en = 2'b01; id_rd_addr = '0; #1;
    n_checks++; if (d0 !== 32'h0 || id_stall !== 1'b0 || rf_rd_en !== 2'b00) begin n_fail++; $display("FAIL x0_read got=%h/%b/%b exp=0/0/00", d0, id_stall, rf_rd_en); end
    tick;
    idle; id_rd_en = 2'b10; id_rd_addr = {5'd0, 5'd0}; #1;
    n_checks++; if (id_stall !== 1'b0 || id_rd_data !== '0) begin n_fail++; $display("FAIL x0_no_pending got=%b/%h exp=0/0", id_stall, id_rd_data); end
    idle; fwd_valid = 3'b001; fwd_addr = {10'd0, 5'd5}; fwd_data = {64'h0, 32'h99}; fwd_data_ok = 3'b000;
    id_rd_en = 2'b00; id_rd_addr = {5'd5, 5'd5}; #1;
    n_checks++; if (id_stall !== 1'b0 || id_rd_data !== '0 || rf_rd_en !== 2'b00) begin n_fail++; $display("FAIL disabled_ch got=%b/%h/%b exp=0/0/00", id_stall, id_rd_data, rf_rd_en); end
    tick;
    idle; lat_issue = 1'b1; lat_issue_addr = 5'd15; tick;
    idle; id_rd_en = 2'b01; id_rd_addr = {5'd0, 5'd15}; #1;
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre got=%b exp=1", id_stall); end
    idle; reset = 1'b1; lat_issue = 1'b1; lat_issue_addr = 5'd16; tick;
    reset = 1'b0; idle; id_rd_en = 2'b11; id_rd_addr = {5'd16, 5'd15}; #1;
    n_checks++; if (id_stall !== 1'b0 || rf_rd_en !== 2'b11) begin n_fail++; $display("FAIL rst_cleared got=%b/%b exp=0/11", id_stall, rf_rd_en); end
    tick;
  endtask

  initial begin
    test_reset;
    test_fwd_priority;
    test_load_use;
    test_scoreboard;
    test_flush;
    test_done_issue_same;
    test_x0_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
